// File: rtl/cpu8_pkg.sv
// Shared definitions for the cpu8 instruction image: field widths, slot packing and
// loader state encoding.
package cpu8_pkg;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned PTR_W  = 5;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned WORD_W = OPC_W + ADDR_W;
    localparam int unsigned IMG_W  = DEPTH * WORD_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Instruction_Memory slices each slot exactly as this packs it
    function automatic logic [WORD_W-1:0] pack_ins(input logic [OPC_W-1:0]  opc,
                                                   input logic [ADDR_W-1:0] addr);
        return {addr, opc};
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams (opcode, address) beats into the packed instruction image and holds the CPU
// while a load is in progress.
module program_loader
    import cpu8_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Clear,
    input  logic [PTR_W-1:0]      Base,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic [OPC_W-1:0]      In_opcode,
    input  logic [ADDR_W-1:0]     In_address,
    input  logic                  In_last,
    output logic [IMG_W-1:0]      Mem_ins,
    output logic                  Cpu_hold,
    output logic [PTR_W:0]        Load_count,
    output logic                  Done,
    output logic                  Overflow_err
);

    localparam logic [PTR_W:0] LAST_COUNT = (PTR_W+1)'(DEPTH - 1);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   load_count_q, load_count_d;
    logic             done_q, done_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             overflow_q, overflow_d;
    logic [IMG_W-1:0] mem_q, mem_d;
    logic             in_ready_c;

    assign in_ready_c = (state_q == ST_LOAD);

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        load_count_d = load_count_q;
        done_d       = done_q;
        cpu_hold_d   = cpu_hold_q;
        overflow_d   = overflow_q;
        mem_d        = mem_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d      = ST_LOAD;
                    wr_ptr_d     = Base;
                    load_count_d = '0;
                    done_d       = 1'b0;
                    overflow_d   = 1'b0;
                    cpu_hold_d   = 1'b1;
                    if (Clear) begin
                        mem_d = '0;
                    end
                end
            end
            ST_LOAD: begin
                if (In_valid) begin
                    mem_d[{wr_ptr_q, 3'b000} +: WORD_W] = pack_ins(In_opcode, In_address);
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    // A full image without In_last still ends the load, flagged as overflow
                    if (In_last || (load_count_q == LAST_COUNT)) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                        overflow_d = ~In_last;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b0;
            overflow_q   <= 1'b0;
            mem_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            load_count_q <= load_count_d;
            done_q       <= done_d;
            cpu_hold_q   <= cpu_hold_d;
            overflow_q   <= overflow_d;
            mem_q        <= mem_d;
        end
    end

    assign In_ready     = in_ready_c;
    assign Mem_ins      = mem_q;
    assign Cpu_hold     = cpu_hold_q;
    assign Load_count   = load_count_q;
    assign Done         = done_q;
    assign Overflow_err = overflow_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: beats update a reference image, completed loads
// queue an expected result that a monitor checks when Done rises.
module tb_program_loader;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic         Clear;
    logic [4:0]   Base;
    logic         In_valid;
    logic         In_ready;
    logic [2:0]   In_opcode;
    logic [4:0]   In_address;
    logic         In_last;
    logic [255:0] Mem_ins;
    logic         Cpu_hold;
    logic [5:0]   Load_count;
    logic         Done;
    logic         Overflow_err;

    program_loader dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Clear(Clear), .Base(Base),
        .In_valid(In_valid), .In_ready(In_ready), .In_opcode(In_opcode),
        .In_address(In_address), .In_last(In_last), .Mem_ins(Mem_ins),
        .Cpu_hold(Cpu_hold), .Load_count(Load_count), .Done(Done),
        .Overflow_err(Overflow_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [255:0] img;
        logic [5:0]   cnt;
        logic         ovf;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [255:0] exp_img = '0;
    int           exp_ptr = 0;
    int           exp_cnt = 0;
    logic         done_prev = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every rising Done must match the oldest queued load result
    always @(negedge Clk) begin
        if (Done === 1'b1 && !done_prev) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 256'(Done), 256'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_image", Mem_ins, e.img);
                chk("sb_count", 256'(Load_count), 256'(e.cnt));
                chk("sb_overflow", 256'(Overflow_err), 256'(e.ovf));
                chk("sb_hold", 256'(Cpu_hold), 256'(0));
                chk("sb_ready", 256'(In_ready), 256'(0));
            end
        end
        done_prev = (Done === 1'b1);
    end

    task automatic do_start(input logic [4:0] b, input logic clr);
        @(posedge Clk); #1;
        Start = 1'b1; Base = b; Clear = clr;
        @(posedge Clk); #1;
        Start = 1'b0; Clear = 1'b0;
        if (clr) exp_img = '0;
        exp_ptr = int'(b);
        exp_cnt = 0;
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [4:0] addr, input logic last);
        int cyc;
        In_valid = 1'b1; In_opcode = op; In_address = addr; In_last = last;
        cyc = 0;
        while (In_ready !== 1'b1 && cyc < 20) begin
            @(posedge Clk); #1;
            cyc++;
        end
        if (In_ready !== 1'b1) begin
            chk("beat_timeout", 256'(In_ready), 256'(1));
        end else begin
            @(posedge Clk); #1;
            exp_img[exp_ptr*8 +: 8] = {addr, op};
            exp_ptr = (exp_ptr + 1) % 32;
            exp_cnt++;
            if (last || exp_cnt == 32) begin
                exp_t e;
                e.img = exp_img; e.cnt = 6'(exp_cnt); e.ovf = ~last;
                sb_q.push_back(e);
            end
        end
        In_valid = 1'b0; In_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Clear = 1'b0; Base = '0;
        In_valid = 1'b0; In_opcode = '0; In_address = '0; In_last = 1'b0;
        #23 Reset = 1'b0;
        #1;
        chk("rst_mem", Mem_ins, 256'(0));
        chk("rst_ready", 256'(In_ready), 256'(0));
        chk("rst_hold", 256'(Cpu_hold), 256'(0));
        chk("rst_count", 256'(Load_count), 256'(0));
        chk("rst_done", 256'(Done), 256'(0));
        chk("rst_ovf", 256'(Overflow_err), 256'(0));

        // Test 1: three-beat program with Clear
        do_start(5'd0, 1'b1);
        chk("t1_hold", 256'(Cpu_hold), 256'(1));
        chk("t1_ready", 256'(In_ready), 256'(1));
        send_beat(3'd5, 5'd7, 1'b0);
        send_beat(3'd1, 5'd0, 1'b0);
        send_beat(3'd2, 5'd31, 1'b1);
        idle(2);
        chk("t1_low_slots", 256'(Mem_ins[23:0]), 256'(24'hFA013D));
        chk("t1_count", 256'(Load_count), 256'(3));

        // Test 2: wrap from slot 31 to slot 0 without Clear
        do_start(5'd31, 1'b0);
        send_beat(3'd7, 5'd1, 1'b0);
        send_beat(3'd0, 5'd2, 1'b1);
        idle(2);
        chk("t2_slot31", 256'(Mem_ins[255:248]), 256'(8'h0F));
        chk("t2_slot0", 256'(Mem_ins[7:0]), 256'(8'h10));
        chk("t2_slots12", 256'(Mem_ins[23:8]), 256'(16'hFA01));
        chk("t2_count", 256'(Load_count), 256'(2));

        // Test 3: 32 beats without last -> overflow; 33rd beat refused
        do_start(5'd0, 1'b0);
        for (int i = 0; i < 32; i++) send_beat(3'(i % 8), 5'(31 - i), 1'b0);
        #1;
        In_valid = 1'b1; In_opcode = 3'd6; In_address = 5'd9;
        chk("t3_ready_after", 256'(In_ready), 256'(0));
        idle(2);
        In_valid = 1'b0;
        chk("t3_image_kept", Mem_ins, exp_img);
        chk("t3_count", 256'(Load_count), 256'(32));
        chk("t3_ovf", 256'(Overflow_err), 256'(1));

        // Test 4: gapped beats with an ignored mid-load Start
        do_start(5'd0, 1'b1);
        send_beat(3'd1, 5'd1, 1'b0);
        idle(1);
        send_beat(3'd2, 5'd2, 1'b0);
        Start = 1'b1; Base = 5'd10; Clear = 1'b1;
        idle(1);
        Start = 1'b0; Clear = 1'b0;
        send_beat(3'd3, 5'd3, 1'b0);
        idle(1);
        send_beat(3'd4, 5'd4, 1'b1);
        idle(1);
        chk("t4_slots", 256'(Mem_ins[31:0]), 256'(32'h24_1B_12_09));
        chk("t4_rest_clear", 256'(Mem_ins[255:32]), 256'(0));
        chk("t4_count", 256'(Load_count), 256'(4));

        // Test 5: reset during a load discards it
        do_start(5'd0, 1'b0);
        send_beat(3'd5, 5'd5, 1'b0);
        send_beat(3'd6, 5'd6, 1'b0);
        #2 Reset = 1'b1;
        #1;
        exp_img = '0;
        chk("t5_mem", Mem_ins, 256'(0));
        chk("t5_ready", 256'(In_ready), 256'(0));
        chk("t5_hold", 256'(Cpu_hold), 256'(0));
        chk("t5_count", 256'(Load_count), 256'(0));
        #1 Reset = 1'b0;
        do_start(5'd5, 1'b0);
        send_beat(3'd3, 5'd12, 1'b1);
        idle(3);
        chk("t5_reload_slot5", 256'(Mem_ins[47:40]), 256'(8'h63));
        chk("t5_done_held", 256'(Done), 256'(1));

        // Test 6: Start with Clear from DONE and no beats
        do_start(5'd3, 1'b1);
        chk("t6_mem", Mem_ins, 256'(0));
        chk("t6_hold", 256'(Cpu_hold), 256'(1));
        chk("t6_ready", 256'(In_ready), 256'(1));
        chk("t6_done", 256'(Done), 256'(0));

        idle(2);
        chk("sb_drained", 256'(sb_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
